// File: rtl/rtr_pkg.sv
// Shared definitions for the local-delivery path: packet field widths/offsets
// and the source identifier used by the merge arbiter.
package rtr_pkg;

   localparam int TICK_WIDTH  = 4;
   localparam int AXON_WIDTH  = 8;
   localparam int LOCAL_WIDTH = TICK_WIDTH + AXON_WIDTH;
   localparam int CNT_WIDTH   = 16;

   // Local packet layout is {tick, axon}
   localparam int AXON_LSB = 0;
   localparam int TICK_LSB = AXON_WIDTH;

   typedef enum logic {
      SRC_NORTH = 1'b0,
      SRC_SOUTH = 1'b1
   } src_e;

endpackage

// File: rtl/local_spike_collector_arb.sv
// Two-way round-robin arbiter: North/South request, one-hot grant, and the
// last-grant state that decides ties.
module rr_arbiter2
   import rtr_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       enable,
   output logic [1:0] gnt
);

   src_e last_q;
   src_e last_d;

   // Grant selection; bit 0 is North, bit 1 is South
   always_comb begin
      gnt    = 2'b00;
      last_d = last_q;
      if (enable) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == SRC_SOUTH) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end else begin
         gnt = 2'b00;
      end
      if (gnt[0]) begin
         last_d = SRC_NORTH;
      end else if (gnt[1]) begin
         last_d = SRC_SOUTH;
      end else begin
         last_d = last_q;
      end
   end

   // Last-grant state; starts at South so North wins the first tie
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= SRC_SOUTH;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/local_spike_collector.sv
// Merges the North and South local-delivery buffers into one registered
// valid/ready stream for the core scheduler, with saturating pop counters.
module local_spike_collector
   import rtr_pkg::*;
#(
   parameter int TICK_WIDTH  = rtr_pkg::TICK_WIDTH,
   parameter int AXON_WIDTH  = rtr_pkg::AXON_WIDTH,
   parameter int LOCAL_WIDTH = TICK_WIDTH + AXON_WIDTH,
   parameter int CNT_WIDTH   = rtr_pkg::CNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [LOCAL_WIDTH-1:0] din_north,
   input  logic                   empty_north,
   output logic                   ren_north,
   input  logic [LOCAL_WIDTH-1:0] din_south,
   input  logic                   empty_south,
   output logic                   ren_south,
   input  logic                   sched_ready,
   output logic                   sched_valid,
   output logic [TICK_WIDTH-1:0]  sched_tick,
   output logic [AXON_WIDTH-1:0]  sched_axon,
   input  logic                   clr_stats,
   output logic [CNT_WIDTH-1:0]   cnt_north,
   output logic [CNT_WIDTH-1:0]   cnt_south,
   output logic                   busy
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic                   valid_q, valid_d;
   logic [LOCAL_WIDTH-1:0] pkt_q, pkt_d;
   logic [CNT_WIDTH-1:0]   cnt_n_q, cnt_n_d;
   logic [CNT_WIDTH-1:0]   cnt_s_q, cnt_s_d;
   logic                   can_load_s;
   logic [1:0]             gnt_s;

   // Holding rst in the enable keeps both pops low during reset
   assign can_load_s = (~valid_q | sched_ready) & rst;

   rr_arbiter2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    ({~empty_south, ~empty_north}),
      .enable (can_load_s),
      .gnt    (gnt_s)
   );

   assign ren_north = gnt_s[0] & rst;
   assign ren_south = gnt_s[1] & rst;

   // Output register next state: reload on grant, else drain on accept
   always_comb begin
      valid_d = valid_q;
      pkt_d   = pkt_q;
      if (gnt_s[0]) begin
         valid_d = 1'b1;
         pkt_d   = din_north;
      end else if (gnt_s[1]) begin
         valid_d = 1'b1;
         pkt_d   = din_south;
      end else if (sched_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Saturating delivery counters; clear wins over a same-cycle pop
   always_comb begin
      cnt_n_d = cnt_n_q;
      cnt_s_d = cnt_s_q;
      if (clr_stats) begin
         cnt_n_d = {CNT_WIDTH{1'b0}};
         cnt_s_d = {CNT_WIDTH{1'b0}};
      end else begin
         if (ren_north && (cnt_n_q != CNT_MAX)) begin
            cnt_n_d = cnt_n_q + CNT_ONE;
         end else begin
            cnt_n_d = cnt_n_q;
         end
         if (ren_south && (cnt_s_q != CNT_MAX)) begin
            cnt_s_d = cnt_s_q + CNT_ONE;
         end else begin
            cnt_s_d = cnt_s_q;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         pkt_q   <= {LOCAL_WIDTH{1'b0}};
         cnt_n_q <= {CNT_WIDTH{1'b0}};
         cnt_s_q <= {CNT_WIDTH{1'b0}};
      end else begin
         valid_q <= valid_d;
         pkt_q   <= pkt_d;
         cnt_n_q <= cnt_n_d;
         cnt_s_q <= cnt_s_d;
      end
   end

   assign sched_valid = valid_q;
   assign sched_tick  = pkt_q[LOCAL_WIDTH-1:AXON_WIDTH];
   assign sched_axon  = pkt_q[AXON_WIDTH-1:0];
   assign cnt_north   = cnt_n_q;
   assign cnt_south   = cnt_s_q;
   assign busy        = valid_q | ~empty_north | ~empty_south;

endmodule

// File: tb/tb_local_spike_collector.sv
// Randomized bench for local_spike_collector: buffer/scheduler models plus a
// one-deep scoreboard predicting pops, the output stream and the counters.
module tb_local_spike_collector;

   localparam int CW = 4;
   localparam int CMAX = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] din_north, din_south;
   logic        empty_north, empty_south;
   logic        ren_north, ren_south;
   logic        sched_ready, sched_valid;
   logic [3:0]  sched_tick;
   logic [7:0]  sched_axon;
   logic        clr_stats;
   logic [CW-1:0] cnt_north, cnt_south;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [11:0] nq[$];
   logic [11:0] sq[$];
   logic [11:0] sb[$];
   int          pop_log[$];
   int          pop_cyc[$];
   logic [11:0] xfer_log[$];
   int          xfer_cyc[$];
   bit          m_last_north;
   int          m_cnt_n, m_cnt_s;

   always #5 clk = ~clk;

   local_spike_collector #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .din_north(din_north), .empty_north(empty_north), .ren_north(ren_north),
      .din_south(din_south), .empty_south(empty_south), .ren_south(ren_south),
      .sched_ready(sched_ready), .sched_valid(sched_valid),
      .sched_tick(sched_tick), .sched_axon(sched_axon),
      .clr_stats(clr_stats), .cnt_north(cnt_north), .cnt_south(cnt_south),
      .busy(busy)
   );

   task automatic drive_heads();
      empty_north = (nq.size() == 0);
      empty_south = (sq.size() == 0);
      din_north   = (nq.size() != 0) ? nq[0] : 12'h000;
      din_south   = (sq.size() != 0) ? sq[0] : 12'h000;
   endtask

   task automatic model_reset();
      sb.delete();
      m_last_north = 1'b0;
      m_cnt_n = 0;
      m_cnt_s = 0;
   endtask

   task automatic clear_logs();
      pop_log.delete(); pop_cyc.delete(); xfer_log.delete(); xfer_cyc.delete();
   endtask

   // One clock cycle: predict, compare, then advance the models at the edge
   task automatic cycle(input logic rdy, input logic clr);
      logic exp_rn, exp_rs, rq_n, rq_s, can_load, exp_valid;
      logic [11:0] head;
      sched_ready = rdy;
      clr_stats = clr;
      drive_heads();
      #1;
      rq_n = (nq.size() != 0);
      rq_s = (sq.size() != 0);
      exp_valid = (sb.size() != 0);
      can_load = !exp_valid || rdy;
      exp_rn = 1'b0; exp_rs = 1'b0;
      if (can_load) begin
         if (rq_n && rq_s) begin
            if (m_last_north) exp_rs = 1'b1; else exp_rn = 1'b1;
         end else if (rq_n) exp_rn = 1'b1;
         else if (rq_s) exp_rs = 1'b1;
      end
      checks++;
      if (ren_north !== exp_rn) begin
         errors++; $display("FAIL ren_north cyc=%0d got=%b exp=%b", cyc, ren_north, exp_rn);
      end
      checks++;
      if (ren_south !== exp_rs) begin
         errors++; $display("FAIL ren_south cyc=%0d got=%b exp=%b", cyc, ren_south, exp_rs);
      end
      checks++;
      if (sched_valid !== exp_valid) begin
         errors++; $display("FAIL sched_valid cyc=%0d got=%b exp=%b", cyc, sched_valid, exp_valid);
      end
      if (exp_valid) begin
         head = sb[0];
         checks++;
         if ({sched_tick, sched_axon} !== head) begin
            errors++; $display("FAIL sched_data cyc=%0d got=%h_%h exp=%h", cyc, sched_tick, sched_axon, head);
         end
      end
      checks++;
      if (busy !== (exp_valid | rq_n | rq_s)) begin
         errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_valid | rq_n | rq_s);
      end
      checks++;
      if (cnt_north !== CW'(m_cnt_n) || cnt_south !== CW'(m_cnt_s)) begin
         errors++; $display("FAIL counters cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, cnt_north, cnt_south, m_cnt_n, m_cnt_s);
      end
      if (sched_valid === 1'b1 && rdy) begin
         xfer_log.push_back({sched_tick, sched_axon});
         xfer_cyc.push_back(cyc);
      end
      @(posedge clk);
      if (rdy && sb.size() != 0) void'(sb.pop_front());
      if (exp_rn) begin
         sb.push_back(nq.pop_front()); m_last_north = 1'b1; pop_log.push_back(0); pop_cyc.push_back(cyc);
      end
      if (exp_rs) begin
         sb.push_back(sq.pop_front()); m_last_north = 1'b0; pop_log.push_back(1); pop_cyc.push_back(cyc);
      end
      if (clr) begin
         m_cnt_n = 0; m_cnt_s = 0;
      end else begin
         if (exp_rn && m_cnt_n < CMAX) m_cnt_n++;
         if (exp_rs && m_cnt_s < CMAX) m_cnt_s++;
      end
      cyc++;
      #1;
      drive_heads();
   endtask

   task automatic drain();
      int n = 0;
      while ((nq.size() != 0 || sq.size() != 0 || sb.size() != 0) && n < 500) begin
         cycle(1'b1, 1'b0);
         n++;
      end
      checks++;
      if (n >= 500) begin
         errors++; $display("FAIL drain_timeout got=%0d/%0d/%0d exp=0/0/0", nq.size(), sq.size(), sb.size());
      end
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      clear_logs();
      for (int i = 0; i < 2; i++) begin
         nq.push_back(12'($urandom)); sq.push_back(12'($urandom));
      end
      drive_heads();
      rst = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (ren_north !== 1'b0 || ren_south !== 1'b0 || sched_valid !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got=%b%b%b exp=000", ren_north, ren_south, sched_valid);
         end
         checks++;
         if (cnt_north !== 4'h0 || cnt_south !== 4'h0 || {sched_tick, sched_axon} !== 12'h000) begin
            errors++; $display("FAIL reset_state got=%h/%h/%h exp=0/0/0", cnt_north, cnt_south, {sched_tick, sched_axon});
         end
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      cycle(1'b1, 1'b0);
      checks++;
      if (pop_log.size() == 0 || pop_log[0] != 0) begin
         errors++; $display("FAIL reset_first_grant got=%0d exp=0(north)", pop_log.size() ? pop_log[0] : -1);
      end
      drain();
   endtask

   task automatic test_single_source();
      logic [11:0] exp[3];
      exp[0] = 12'h3A5; exp[1] = 12'h012; exp[2] = 12'hFFF;
      cycle(1'b1, 1'b1);
      clear_logs();
      for (int i = 0; i < 3; i++) nq.push_back(exp[i]);
      drain();
      checks++;
      if (xfer_log.size() != 3) begin
         errors++; $display("FAIL single_count got=%0d exp=3", xfer_log.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (xfer_log[i] !== exp[i] || xfer_cyc[i] != pop_cyc[0] + 1 + i) begin
               errors++; $display("FAIL single_xfer%0d got=%h@%0d exp=%h@%0d", i, xfer_log[i], xfer_cyc[i], exp[i], pop_cyc[0] + 1 + i);
            end
         end
      end
      checks++;
      if (cnt_north !== 4'd3) begin
         errors++; $display("FAIL single_cnt got=%0d exp=3", cnt_north);
      end
   endtask

   task automatic test_fairness();
      apply_reset();
      clear_logs();
      for (int i = 0; i < 4; i++) begin
         nq.push_back(12'($urandom)); sq.push_back(12'($urandom));
      end
      drain();
      checks++;
      if (pop_log.size() != 8 || xfer_log.size() != 8) begin
         errors++; $display("FAIL fair_count got=%0d/%0d exp=8/8", pop_log.size(), xfer_log.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (pop_log[i] != (i % 2) || xfer_cyc[i] != xfer_cyc[0] + i) begin
               errors++; $display("FAIL fair_order%0d got=%0d@%0d exp=%0d@%0d", i, pop_log[i], xfer_cyc[i], i % 2, xfer_cyc[0] + i);
            end
         end
      end
      checks++;
      if (cnt_north !== 4'd4 || cnt_south !== 4'd4) begin
         errors++; $display("FAIL fair_cnt got=%0d/%0d exp=4/4", cnt_north, cnt_south);
      end
   endtask

   task automatic test_backpressure();
      logic [11:0] p[3];
      for (int i = 0; i < 3; i++) begin
         p[i] = 12'($urandom); nq.push_back(p[i]);
      end
      cycle(1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 1'b0);
         checks++;
         if ({sched_tick, sched_axon} !== p[0] || sched_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold%0d got=%b/%h exp=1/%h", k, sched_valid, {sched_tick, sched_axon}, p[0]);
         end
      end
      cycle(1'b1, 1'b0);
      checks++;
      if ({sched_tick, sched_axon} !== p[1] || sched_valid !== 1'b1) begin
         errors++; $display("FAIL bp_reload got=%b/%h exp=1/%h", sched_valid, {sched_tick, sched_axon}, p[1]);
      end
      drain();
   endtask

   task automatic test_saturation_clear();
      cycle(1'b1, 1'b1);
      for (int i = 0; i < 20; i++) nq.push_back(12'($urandom));
      drain();
      checks++;
      if (cnt_north !== 4'd15) begin
         errors++; $display("FAIL sat_cnt got=%0d exp=15", cnt_north);
      end
      nq.push_back(12'($urandom)); nq.push_back(12'($urandom));
      cycle(1'b1, 1'b1);
      checks++;
      if (cnt_north !== 4'd0) begin
         errors++; $display("FAIL clr_pop got=%0d exp=0", cnt_north);
      end
      drain();
      checks++;
      if (cnt_north !== 4'd1) begin
         errors++; $display("FAIL clr_after got=%0d exp=1", cnt_north);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 4; i++) begin
         nq.push_back(12'($urandom)); sq.push_back(12'($urandom));
      end
      repeat (3) cycle(1'b1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (sched_valid !== 1'b0 || ren_north !== 1'b0 || ren_south !== 1'b0) begin
         errors++; $display("FAIL async_rst got=%b%b%b exp=000", sched_valid, ren_north, ren_south);
      end
      model_reset();
      #1;
      rst = 1'b1;
      clear_logs();
      cycle(1'b1, 1'b0);
      checks++;
      if (pop_log.size() == 0 || pop_log[0] != 0) begin
         errors++; $display("FAIL async_first_grant got=%0d exp=0(north)", pop_log.size() ? pop_log[0] : -1);
      end
      drain();
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 2) != 0 && nq.size() < 6) nq.push_back(12'($urandom));
         if ($urandom_range(0, 2) != 0 && sq.size() < 6) sq.push_back(12'($urandom));
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
      end
      drain();
   endtask

   initial begin
      rst = 1'b1;
      sched_ready = 1'b0;
      clr_stats = 1'b0;
      drive_heads();
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_single_source();
      test_fairness();
      test_backpressure();
      test_saturation_clear();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
